// File: rtl/emu_xact_sequencer.sv
// emu_xact_sequencer: turns a host byte stream into tester-bus transactions.
// Frame = header N (DUT clock count) + NUM_STIM stimulus bytes; the reply is the
// NUM_OUT captured output bytes, vectOut[0] first. Every output is a flop; the
// combinational block computes next values and the sequential block loads them.
module emu_xact_sequencer #(
    parameter int NUM_STIM = 2,
    parameter int NUM_OUT  = 2,
    parameter int CLK_HI   = 2,
    parameter int CLK_LO   = 2
) (
    input  logic       clk_emu,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] Din_emu,
    output logic [2:0] Addr_emu,
    output logic       load_emu,
    output logic       get_emu,
    input  logic [7:0] Dout_emu,
    output logic       clk_dut,
    output logic       busy
);

    localparam int PH_MAX = (CLK_HI > CLK_LO) ? CLK_HI : CLK_LO;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0] HI_LAST   = PH_W'(CLK_HI - 1);
    localparam logic [PH_W-1:0] LO_LAST   = PH_W'(CLK_LO - 1);
    localparam logic [2:0]      STIM_LAST = 3'(NUM_STIM - 1);
    localparam logic [2:0]      OUT_LAST  = 3'(NUM_OUT - 1);

    typedef enum logic [3:0] {
        S_HDR, S_STIM, S_LOAD, S_CKH, S_CKL, S_GET, S_RADDR, S_RWAIT, S_TX
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      n_cnt, n_cnt_nxt;     // DUT clocks still to run
    logic [2:0]      idx, idx_nxt;         // stim index in STIM, output index j in readout
    logic [PH_W-1:0] ph, ph_nxt;           // cycles spent in the current clk_dut phase
    logic            wcnt, wcnt_nxt;       // readout wait for the tester's registered Dout

    logic       rx_ready_nxt, tx_valid_nxt, load_nxt, get_nxt, clk_dut_nxt, busy_nxt;
    logic [7:0] tx_data_nxt, din_nxt;
    logic [2:0] addr_nxt;

    // State and all output flops; reset aborts any transaction immediately.
    always_ff @(posedge clk_emu) begin
        if (reset) begin
            state    <= S_HDR;
            n_cnt    <= 8'd0;
            idx      <= 3'd0;
            ph       <= '0;
            wcnt     <= 1'b0;
            rx_ready <= 1'b1;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
            Din_emu  <= 8'd0;
            Addr_emu <= 3'd0;
            load_emu <= 1'b0;
            get_emu  <= 1'b0;
            clk_dut  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            n_cnt    <= n_cnt_nxt;
            idx      <= idx_nxt;
            ph       <= ph_nxt;
            wcnt     <= wcnt_nxt;
            rx_ready <= rx_ready_nxt;
            tx_data  <= tx_data_nxt;
            tx_valid <= tx_valid_nxt;
            Din_emu  <= din_nxt;
            Addr_emu <= addr_nxt;
            load_emu <= load_nxt;
            get_emu  <= get_nxt;
            clk_dut  <= clk_dut_nxt;
            busy     <= busy_nxt;
        end
    end

    // Next-state and next-output decode; everything holds unless a state moves it.
    always_comb begin
        state_nxt    = state;
        n_cnt_nxt    = n_cnt;
        idx_nxt      = idx;
        ph_nxt       = ph;
        wcnt_nxt     = wcnt;
        rx_ready_nxt = rx_ready;
        tx_data_nxt  = tx_data;
        tx_valid_nxt = tx_valid;
        din_nxt      = Din_emu;
        addr_nxt     = Addr_emu;
        load_nxt     = 1'b0;
        get_nxt      = 1'b0;
        clk_dut_nxt  = 1'b0;
        busy_nxt     = busy;

        case (state)
            S_HDR: begin
                if (rx_valid && rx_ready) begin
                    n_cnt_nxt = rx_data;
                    busy_nxt  = 1'b1;
                    idx_nxt   = 3'd0;
                    state_nxt = S_STIM;
                end
            end
            S_STIM: begin
                if (rx_valid && rx_ready) begin
                    din_nxt  = rx_data;
                    addr_nxt = idx;
                    idx_nxt  = idx + 3'd1;
                    if (idx == STIM_LAST) begin
                        rx_ready_nxt = 1'b0;
                        state_nxt    = S_LOAD;
                    end
                end
            end
            // First LOAD cycle leaves the final stim byte alone for a full cycle,
            // second cycle drives the one-cycle load strobe.
            S_LOAD: begin
                if (!load_emu) begin
                    load_nxt = 1'b1;
                end else begin
                    ph_nxt    = '0;
                    state_nxt = (n_cnt == 8'd0) ? S_GET : S_CKH;
                end
            end
            S_CKH: begin
                clk_dut_nxt = 1'b1;
                if (ph == HI_LAST) begin
                    ph_nxt    = '0;
                    state_nxt = S_CKL;
                end else begin
                    ph_nxt = ph + PH_W'(1);
                end
            end
            S_CKL: begin
                if (ph == LO_LAST) begin
                    ph_nxt    = '0;
                    n_cnt_nxt = n_cnt - 8'd1;
                    state_nxt = (n_cnt == 8'd1) ? S_GET : S_CKH;
                end else begin
                    ph_nxt = ph + PH_W'(1);
                end
            end
            S_GET: begin
                if (!get_emu) begin
                    get_nxt = 1'b1;
                end else begin
                    idx_nxt   = 3'd0;
                    state_nxt = S_RADDR;
                end
            end
            S_RADDR: begin
                addr_nxt  = idx;
                wcnt_nxt  = 1'b0;
                state_nxt = S_RWAIT;
            end
            // Tester registers Dout one cycle after Addr; sample on the second cycle.
            S_RWAIT: begin
                if (!wcnt) begin
                    wcnt_nxt = 1'b1;
                end else begin
                    tx_data_nxt  = Dout_emu;
                    tx_valid_nxt = 1'b1;
                    state_nxt    = S_TX;
                end
            end
            S_TX: begin
                if (tx_valid && tx_ready) begin
                    tx_valid_nxt = 1'b0;
                    if (idx == OUT_LAST) begin
                        busy_nxt     = 1'b0;
                        rx_ready_nxt = 1'b1;
                        state_nxt    = S_HDR;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        state_nxt = S_RADDR;
                    end
                end
            end
            default: begin
                rx_ready_nxt = 1'b1;
                tx_valid_nxt = 1'b0;
                busy_nxt     = 1'b0;
                state_nxt    = S_HDR;
            end
        endcase
    end

endmodule

// File: tb/tb_emu_xact_sequencer.sv
// Bench for emu_xact_sequencer: tester wrapper plus an 8x8 multiplier DUT model,
// a negedge monitor for strobe/clock timing, and directed frame scenarios.
module tb_emu_xact_sequencer;

    logic       clk_emu = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] Din_emu;
    logic [2:0] Addr_emu;
    logic       load_emu, get_emu;
    logic [7:0] Dout_emu;
    logic       clk_dut;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    emu_xact_sequencer #(.NUM_STIM(2), .NUM_OUT(2), .CLK_HI(2), .CLK_LO(2)) dut (
        .clk_emu(clk_emu), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .Din_emu(Din_emu), .Addr_emu(Addr_emu), .load_emu(load_emu), .get_emu(get_emu),
        .Dout_emu(Dout_emu), .clk_dut(clk_dut), .busy(busy)
    );

    always #5 clk_emu = ~clk_emu;

    // Tester wrapper model: stimIn written every cycle, load copies to DUT inputs,
    // get captures DUT outputs, Dout is a registered read of vectOut.
    logic [7:0]  stim [8];
    logic [7:0]  vout [8];
    logic [7:0]  dut_a, dut_b;
    logic [15:0] prod;

    always @(posedge clk_emu) begin
        stim[Addr_emu] <= Din_emu;
        if (load_emu) begin
            dut_a <= stim[0];
            dut_b <= stim[1];
        end
        if (get_emu) begin
            vout[0] <= prod[7:0];
            vout[1] <= prod[15:8];
        end
        Dout_emu <= vout[Addr_emu];
    end

    always @(posedge clk_dut) prod <= dut_a * dut_b;

    // Timing monitor: cumulative counters; tests look at deltas.
    logic       p_load = 1'b0, p_get = 1'b0, p_clk = 1'b0;
    logic [7:0] p_din = 8'd0;
    logic [2:0] p_addr = 3'd0;
    int load_rise = 0, load_cyc = 0, get_rise = 0, get_cyc = 0, rise = 0;
    int overlap = 0, setup_err = 0, clk_ld_err = 0, hi_err = 0, lo_err = 0, gap_err = 0;
    int hi_run = 0, lo_run = 100;
    bit in_burst = 1'b0;

    always @(negedge clk_emu) begin
        p_load <= load_emu; p_get <= get_emu; p_clk <= clk_dut;
        p_din <= Din_emu; p_addr <= Addr_emu;
        if (load_emu) load_cyc <= load_cyc + 1;
        if (get_emu) get_cyc <= get_cyc + 1;
        if (load_emu && get_emu) overlap <= overlap + 1;
        if (load_emu && !p_load) begin
            load_rise <= load_rise + 1;
            if (Din_emu !== p_din || Addr_emu !== p_addr) setup_err <= setup_err + 1;
        end
        if (get_emu && !p_get) begin
            get_rise <= get_rise + 1;
            if (lo_run < 2) gap_err <= gap_err + 1;
            in_burst <= 1'b0;
        end
        if (clk_dut && !p_clk) begin
            rise <= rise + 1;
            hi_run <= 1;
            if (p_load || load_emu) clk_ld_err <= clk_ld_err + 1;
            if (in_burst && lo_run != 2) lo_err <= lo_err + 1;
        end else if (clk_dut) begin
            hi_run <= hi_run + 1;
        end
        if (!clk_dut && p_clk) begin
            if (hi_run != 2) hi_err <= hi_err + 1;
            lo_run <= 1;
            in_burst <= 1'b1;
        end else if (!clk_dut && lo_run < 1000) begin
            lo_run <= lo_run + 1;
        end
        if (reset) in_burst <= 1'b0;
    end

    // Offer one byte from a negedge; returns at the negedge after it was taken.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data = b; rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 200) begin @(negedge clk_emu); t++; end
        if (t >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: rx_ready=%b required 1", rx_ready);
        end
        @(negedge clk_emu); rx_valid = 1'b0;
    endtask

    // Accept one reply byte; returns at the negedge after the handshake.
    task automatic recv_byte(output logic [7:0] b);
        int t = 0;
        tx_ready = 1'b1;
        while (tx_valid !== 1'b1 && t < 3000) begin @(negedge clk_emu); t++; end
        if (t >= 3000) begin
            n_checks++; n_fail++;
            $display("FAIL recv_timeout: tx_valid=%b required 1", tx_valid);
        end
        b = tx_data;
        @(negedge clk_emu); tx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_emu);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rx_ready: got %b want 1", rx_ready); end
        n_checks++; if ({tx_valid, load_emu, get_emu, clk_dut, busy} !== 5'b0) begin n_fail++; $display("FAIL rst_strobes: got %b want 00000", {tx_valid, load_emu, get_emu, clk_dut, busy}); end
        n_checks++; if ({tx_data, Din_emu, Addr_emu} !== 19'd0) begin n_fail++; $display("FAIL rst_data: got %h want 0", {tx_data, Din_emu, Addr_emu}); end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_single_clock();
        int b_ld = load_rise, b_lc = load_cyc, b_gr = get_rise, b_gc = get_cyc, b_r = rise;
        int b_su = setup_err, b_cl = clk_ld_err, b_hi = hi_err, b_gap = gap_err;
        logic [7:0] r0, r1;
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        recv_byte(r0); recv_byte(r1);
        idle(3);
        n_checks++; if (r0 !== 8'hA8) begin n_fail++; $display("FAIL t1_r0: got %h want a8", r0); end
        n_checks++; if (r1 !== 8'h03) begin n_fail++; $display("FAIL t1_r1: got %h want 03", r1); end
        n_checks++; if (load_rise - b_ld != 1 || load_cyc - b_lc != 1) begin n_fail++; $display("FAIL t1_load: rises %0d cycles %0d want 1 1", load_rise - b_ld, load_cyc - b_lc); end
        n_checks++; if (get_rise - b_gr != 1 || get_cyc - b_gc != 1) begin n_fail++; $display("FAIL t1_get: rises %0d cycles %0d want 1 1", get_rise - b_gr, get_cyc - b_gc); end
        n_checks++; if (rise - b_r != 1) begin n_fail++; $display("FAIL t1_clk_rises: got %0d want 1", rise - b_r); end
        n_checks++; if (setup_err != b_su || clk_ld_err != b_cl || hi_err != b_hi || gap_err != b_gap) begin n_fail++; $display("FAIL t1_timing: setup %0d clk_ld %0d hi %0d gap %0d want 0", setup_err - b_su, clk_ld_err - b_cl, hi_err - b_hi, gap_err - b_gap); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy: got %b want 0", busy); end
    endtask

    task automatic test_zero_clocks();
        int b_ld = load_rise, b_gr = get_rise, b_r = rise, b_ov = overlap;
        logic [7:0] r0, r1;
        send_byte(8'h00);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t2_busy_hi: got %b want 1", busy); end
        send_byte(8'hAA); send_byte(8'h55);
        recv_byte(r0); recv_byte(r1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t2_busy_lo: got %b want 0", busy); end
        idle(3);
        n_checks++; if (rise - b_r != 0) begin n_fail++; $display("FAIL t2_clk_rises: got %0d want 0", rise - b_r); end
        n_checks++; if (load_rise - b_ld != 1 || get_rise - b_gr != 1 || overlap != b_ov) begin n_fail++; $display("FAIL t2_strobes: load %0d get %0d overlap %0d want 1 1 0", load_rise - b_ld, get_rise - b_gr, overlap - b_ov); end
        n_checks++; if ({r1, r0} !== 16'h03A8) begin n_fail++; $display("FAIL t2_reply: got %h want 03a8", {r1, r0}); end
    endtask

    task automatic test_max_clocks();
        int b_r = rise, b_hi = hi_err, b_lo = lo_err, b_gap = gap_err, b_gr = get_rise;
        logic [7:0] r0, r1;
        send_byte(8'hFF); send_byte(8'h02); send_byte(8'h03);
        recv_byte(r0); recv_byte(r1);
        idle(3);
        n_checks++; if (rise - b_r != 255) begin n_fail++; $display("FAIL t3_clk_rises: got %0d want 255", rise - b_r); end
        n_checks++; if (hi_err != b_hi || lo_err != b_lo) begin n_fail++; $display("FAIL t3_phase: hi %0d lo %0d want 0 0", hi_err - b_hi, lo_err - b_lo); end
        n_checks++; if (gap_err != b_gap || get_rise - b_gr != 1) begin n_fail++; $display("FAIL t3_get: gap %0d rises %0d want 0 1", gap_err - b_gap, get_rise - b_gr); end
        n_checks++; if ({r1, r0} !== 16'h0006) begin n_fail++; $display("FAIL t3_reply: got %h want 0006", {r1, r0}); end
    endtask

    task automatic test_backpressure();
        int t = 0, bad = 0;
        logic [7:0] d0, r0, r1;
        logic [2:0] a0;
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h10);
        while (tx_valid !== 1'b1 && t < 200) begin @(negedge clk_emu); t++; end
        d0 = tx_data; a0 = Addr_emu;
        rx_data = 8'h77; rx_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_emu);
            if (tx_valid !== 1'b1 || tx_data !== d0 || Addr_emu !== a0 || rx_ready !== 1'b0) bad++;
        end
        rx_valid = 1'b0;
        n_checks++; if (bad != 0 || t >= 200) begin n_fail++; $display("FAIL t4_hold: %0d unstable cycles, wait %0d, want 0", bad, t); end
        recv_byte(r0); recv_byte(r1);
        n_checks++; if (r0 !== 8'h00 || d0 !== 8'h00) begin n_fail++; $display("FAIL t4_r0: got %h/%h want 00", r0, d0); end
        n_checks++; if (r1 !== 8'h01) begin n_fail++; $display("FAIL t4_r1: got %h want 01", r1); end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        logic [7:0] r0, r1;
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
        while (clk_dut !== 1'b1 && t < 50) begin @(negedge clk_emu); t++; end
        reset = 1'b1;
        idle(1);
        n_checks++; if (clk_dut !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b0 || t >= 50) begin n_fail++; $display("FAIL t5_abort: clk %b txv %b rxr %b busy %b want 0 0 1 0", clk_dut, tx_valid, rx_ready, busy); end
        idle(1);
        reset = 1'b0;
        idle(1);
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        recv_byte(r0); recv_byte(r1);
        n_checks++; if ({r1, r0} !== 16'h03A8) begin n_fail++; $display("FAIL t5_reply: got %h want 03a8", {r1, r0}); end
    endtask

    task automatic test_rx_gaps();
        int b_ld = load_rise, b_gr = get_rise, b_r = rise, b_ov = overlap, b_su = setup_err;
        logic [7:0] r0, r1;
        send_byte(8'h01); idle(3);
        send_byte(8'h12); idle(3);
        send_byte(8'h34);
        recv_byte(r0); recv_byte(r1);
        idle(3);
        n_checks++; if (load_rise - b_ld != 1 || get_rise - b_gr != 1 || rise - b_r != 1) begin n_fail++; $display("FAIL t6_counts: load %0d get %0d clk %0d want 1 1 1", load_rise - b_ld, get_rise - b_gr, rise - b_r); end
        n_checks++; if (overlap != b_ov || setup_err != b_su) begin n_fail++; $display("FAIL t6_overlap: overlap %0d setup %0d want 0 0", overlap - b_ov, setup_err - b_su); end
        n_checks++; if ({r1, r0} !== 16'h03A8) begin n_fail++; $display("FAIL t6_reply: got %h want 03a8", {r1, r0}); end
    endtask

    initial begin
        @(negedge clk_emu);
        test_reset();
        test_single_clock();
        test_zero_clocks();
        test_max_clocks();
        test_backpressure();
        test_reset_mid();
        test_rx_gaps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
